// File: rtl/lock_counter.sv
// lock_counter: five-bit loadable up/down counter for the encoded lock machine.
// Holds the lock's current position/step count. It can capture the lock FSM's
// previous state code, or step up/down by one modulo 32.
// Control priority on each rising CLK edge: RST, then EN (load), then sel.
// sel encoding: 00 hold, 01 increment, 10 decrement, 11 reload from prevState.
// numCounter comes straight from the register, so there is no
// combinational path from any input to the output.
module lock_counter (
    input  logic       CLK,
    input  logic       RST,
    input  logic       EN,
    input  logic [1:0] sel,
    input  logic [4:0] prevState,
    output logic [4:0] numCounter
);

    localparam logic [1:0] SEL_HOLD   = 2'b00;
    localparam logic [1:0] SEL_INC    = 2'b01;
    localparam logic [1:0] SEL_DEC    = 2'b10;
    localparam logic [1:0] SEL_RELOAD = 2'b11;

    logic [4:0] count_q;

    // Counter register: the reset clear wins over a load, and a load wins over sel.
    // Increment and decrement are plain 5-bit arithmetic, so 31+1 wraps to 0
    // and 0-1 wraps to 31. No carry or borrow flag is kept.
    always_ff @(posedge CLK) begin
        if (RST) begin
            count_q <= 5'd0;
        end else if (EN) begin
            count_q <= prevState;
        end else begin
            case (sel)
                SEL_HOLD:   count_q <= count_q;
                SEL_INC:    count_q <= count_q + 5'd1;
                SEL_DEC:    count_q <= count_q - 5'd1;
                SEL_RELOAD: count_q <= prevState;
                default:    count_q <= count_q;
            endcase
        end
    end

    assign numCounter = count_q;

endmodule

// File: tb/tb_lock_counter.sv
// tb_lock_counter: directed steps from the lock_counter test plan, followed by
// randomized traffic. Each edge is checked against an arithmetic reference model.
module tb_lock_counter;

    logic       CLK = 1'b0;
    logic       RST;
    logic       EN;
    logic [1:0] sel;
    logic [4:0] prevState;
    logic [4:0] numCounter;

    int         vectors     = 0;
    int         miscompares = 0;
    int         model_cnt   = 0;

    lock_counter dut (
        .CLK        (CLK),
        .RST        (RST),
        .EN         (EN),
        .sel        (sel),
        .prevState  (prevState),
        .numCounter (numCounter)
    );

    // clock/reset block: free-running clock, all inputs start in reset
    always #5 CLK = ~CLK;

    // Reference model: next count as an integer 0..31 from the control rules
    function automatic int ref_next(input int cur, input logic r, input logic e,
                                    input logic [1:0] s, input logic [4:0] p);
        if (r === 1'b1) return 0;
        if (e === 1'b1) return int'(p);
        case (s)
            2'd1:    return (cur + 1) % 32;
            2'd2:    return (cur + 31) % 32;
            2'd3:    return int'(p);
            default: return cur;
        endcase
    endfunction

    // Driver: apply one cycle of controls, advance the model, check against it
    task automatic step(input string tag, input logic r, input logic e,
                        input logic [1:0] s, input logic [4:0] p);
        @(negedge CLK);
        RST = r; EN = e; sel = s; prevState = p;
        @(posedge CLK);
        model_cnt = ref_next(model_cnt, r, e, s, p);
        #1;
        vectors++;
        assert (numCounter === 5'(model_cnt)) else begin
            miscompares++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, numCounter, model_cnt);
        end
    endtask

    // Directed check of the current count against a plan constant
    task automatic expect_val(input string tag, input int exp);
        vectors++;
        assert (numCounter === 5'(exp)) else begin
            miscompares++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, numCounter, exp);
        end
    endtask

    initial begin
        RST = 1'b1; EN = 1'bx; sel = 2'bxx; prevState = 5'd0;

        // reset with unknown controls, then held for three more edges
        step("rst_x", 1'b1, 1'bx, 2'bxx, 5'd0);       expect_val("rst_x_c", 0);
        for (int i = 0; i < 3; i++) begin
            step("rst_hold", 1'b1, 1'b0, 2'b00, 5'd3); expect_val("rst_hold_c", 0);
        end

        // load through EN, then hold
        step("load1", 1'b0, 1'b1, 2'b00, 5'b10010);    expect_val("load1_c", 18);
        step("load2", 1'b0, 1'b1, 2'b00, 5'b10010);    expect_val("load2_c", 18);
        step("hold", 1'b0, 1'b0, 2'b00, 5'd0);         expect_val("hold_c", 18);

        // count up, reset in the middle of counting, resume
        step("up1", 1'b0, 1'b0, 2'b01, 5'd0);          expect_val("up1_c", 19);
        step("up2", 1'b0, 1'b0, 2'b01, 5'd0);          expect_val("up2_c", 20);
        for (int i = 0; i < 3; i++) begin
            step("rst_mid", 1'b1, 1'b0, 2'b01, 5'd0);  expect_val("rst_mid_c", 0);
        end
        for (int i = 0; i < 5; i++) begin
            step("idle", 1'b0, 1'b0, 2'b00, 5'd0);     expect_val("idle_c", 0);
        end
        step("resume1", 1'b0, 1'b0, 2'b01, 5'd0);      expect_val("resume1_c", 1);
        step("resume2", 1'b0, 1'b0, 2'b01, 5'd0);      expect_val("resume2_c", 2);

        // reload through sel=11; prevState changes while holding are ignored
        for (int i = 0; i < 4; i++) begin
            step("reload", 1'b0, 1'b0, 2'b11, 5'd18);  expect_val("reload_c", 18);
        end
        for (int i = 0; i < 3; i++) begin
            step("hold_ps", 1'b0, 1'b0, 2'b00, 5'd5);  expect_val("hold_ps_c", 18);
        end
        step("reload2", 1'b0, 1'b0, 2'b11, 5'd18);     expect_val("reload2_c", 18);

        // wrap in both directions
        step("ld31", 1'b0, 1'b1, 2'b00, 5'd31);        expect_val("ld31_c", 31);
        step("wrap_up", 1'b0, 1'b0, 2'b01, 5'd0);      expect_val("wrap_up_c", 0);
        step("after_wrap", 1'b0, 1'b0, 2'b01, 5'd0);   expect_val("after_wrap_c", 1);
        step("rst0", 1'b1, 1'b0, 2'b00, 5'd0);         expect_val("rst0_c", 0);
        step("wrap_dn", 1'b0, 1'b0, 2'b10, 5'd0);      expect_val("wrap_dn_c", 31);
        step("dn2", 1'b0, 1'b0, 2'b10, 5'd0);          expect_val("dn2_c", 30);

        // priority: load beats increment, reset beats load
        step("en_over_sel", 1'b0, 1'b1, 2'b01, 5'd7);  expect_val("en_over_sel_c", 7);
        step("rst_over_en", 1'b1, 1'b1, 2'b11, 5'd9);  expect_val("rst_over_en_c", 0);

        // a one-bit sel value zero-extends to increment
        step("sel_1bit", 1'b0, 1'b0, 1'b1, 5'd0);      expect_val("sel_1bit_c", 1);

        // randomized traffic against the reference model
        for (int i = 0; i < 400; i++) begin
            step("rand",
                 ($urandom_range(0, 15) == 0),
                 ($urandom_range(0, 7) == 0),
                 2'($urandom_range(0, 3)),
                 5'($urandom_range(0, 31)));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
